mul_datapath: RTL and testbench
===============================

# mul_datapath

Datapath and request/response front-end for the 4-bit shift-add sequential multiplier. It accepts operand pairs through a valid/ready handshake and generates the one-cycle start pulse for `mul_controller`. It executes the add and shift steps that the controller commands, returning the multiplier LSB and step count to it. It holds the 8-bit product in a result register until the downstream consumer takes it.

## Interface
- `WIDTH`, 4: operand width. The product is 2·`WIDTH`. The step counter is 2 bits, so only 4 is supported.
- `clk_i`  input  1  clock; all state updates on the rising edge.
- `reset_i`  input  1  synchronous, active-high reset.
- `req_valid_i`  input  1  operands valid.
- `req_ready_o`  output  1  block can accept operands.
- `multiplicand_i`  input  4  operand M.
- `multiplier_i`  input  4  operand Q.
- `mul_enable_o`  output  1  start pulse to the controller: `req_valid_i & req_ready_o`.
- `load_reg_i`  input  1  from the controller: capture operands.
- `add_i`  input  1  from the controller: add phase.
- `mux_ctrl_i`  input  1  from the controller: add select (1 = M, 0 = zero).
- `shift_ena_i`  input  1  from the controller: shift phase.
- `step_count_o`  output  2  to the controller: remaining-steps counter.
- `mul_lsb_o`  output  1  to the controller: Q[0].
- `result_valid_o`  output  1  product valid.
- `result_ready_i`  input  1  consumer accepts the product.
- `product_o`  output  8  registered product.

## Operation
Registers:
- A: 5-bit accumulator, A[4] = carry.
- Q: 4 bits.
- M: 4 bits.
- cnt: 2 bits.
- busy: 1 bit.
- res: 8 bits.
- rv: 1 bit.

Control and handshake:
- `req_ready_o = ~busy & ~rv`. This is combinational; no new job is accepted while a result is pending.
- Operand load: `load_reg_i` → A=0, Q=`multiplier_i`, M=`multiplicand_i`, cnt=3, busy=1.

Add phase:
- On `add_i`: A = A[3:0] + (`mux_ctrl_i` ? M : 0), computed at 5-bit width.
- Q, M and cnt are held during the add phase.

Shift phase:
- On `shift_ena_i`, logically shift {A,Q} right by 1: A = {0,A[4:1]}, Q = {A[0],Q[3:1]}.
- cnt decrements by 1.

Completion:
- A `shift_ena_i` while cnt==0 is the final step.
- On the final step, in the same edge: res = {A[3:0],Q} as post-shift values (equivalently {A[4:0],Q[3:1]} pre-shift), rv=1, busy=0.
- On the final step cnt wraps to 3. This is harmless because cnt is reloaded on every load.

Outputs:
- `step_count_o = cnt`, `mul_lsb_o = Q[0]`, `product_o = res`, `result_valid_o = rv`.
- rv clears on `rv & result_ready_i`. res holds its value until the next completion.

Boundary conditions:
- `load_reg_i`, `add_i` and `shift_ena_i` are mutually exclusive by controller construction. If several are asserted anyway, priority is load > add > shift.
- `load_reg_i` asserted while busy is a protocol error and reloads the job.
- Control inputs asserted while idle do not alter res or rv.

Reset:
- All registers clear to 0.
- Post-reset outputs: `req_ready_o`=1, `result_valid_o`=0, `product_o`=0, `step_count_o`=0, `mul_lsb_o`=0.
- Reset mid-operation abandons the job. The controller is on the same reset and also returns to IDLE.

## Timing
- Accept at cycle T: `req_valid_i & req_ready_o` is high, so `mul_enable_o` pulses and the controller asserts `load_reg_i` in the same cycle.
- Add cycles: T+1, T+3, T+5, T+7.
- Shift cycles: T+2, T+4, T+6, T+8. The controller sees cnt = 3, 2, 1, 0 on these cycles respectively.
- `result_valid_o` rises at T+9. Latency from accept to result is 9 cycles.
- Earliest re-accept is the cycle after the result is consumed. Back-to-back throughput is 10 cycles per product with `result_ready_i` tied high.
- `req_ready_o` falls at T+1 and does not depend on `req_valid_i`, so there is no combinational loop.
- `mul_enable_o` depends combinationally on `req_valid_i`.

## Test plan
- Reset, then check all outputs: `req_ready_o`=1, others 0.
- M=5, Q=3, `result_ready_i`=1 → `product_o`=0x0F at T+9, `result_valid_o` high for 1 cycle.
- Carry path: M=15, Q=15 → 0xE1. Also M=13, Q=11 → 0x8F. Check cnt sequence 3, 2, 1, 0 on the shift cycles.
- Zero operands: M=0, Q=9 → 0x00 and M=9, Q=0 → 0x00. `mux_ctrl_i` must stay low throughout the Q=0 case.
- Backpressure: hold `result_ready_i`=0 for 5 cycles after completion with `req_valid_i`=1 → `req_ready_o`=0, no `mul_enable_o`, product stable. Release → result consumed, new job accepted the next cycle.
- Assert `reset_i` at T+4 mid-job → next cycle all outputs at reset values. A following job M=7, Q=6 → 0x2A.

Source files
------------

// File: rtl/mul_datapath.sv
// mul_datapath
// ------------
// Datapath and request/response front-end for the 4-bit shift-add sequential
// multiplier. Operand pairs arrive over a valid/ready handshake; an accepted
// request produces a one-cycle start pulse for mul_controller. The controller
// then sequences load / add / shift steps, which this block executes on the
// accumulator A (with carry), the multiplier register Q and the multiplicand
// register M. The 8-bit product is held in a result register until the
// downstream consumer takes it.
//
// Ports
//   clk_i           clock, rising-edge
//   reset_i         synchronous active-high reset
//   req_valid_i     operands valid
//   req_ready_o     block can accept operands (idle and no result pending)
//   multiplicand_i  operand M
//   multiplier_i    operand Q
//   mul_enable_o    start pulse to the controller (request handshake)
//   load_reg_i      controller: capture operands, start a job
//   add_i           controller: add phase
//   mux_ctrl_i      controller: add select (1 = M, 0 = zero)
//   shift_ena_i     controller: shift phase
//   step_count_o    controller: remaining-steps counter
//   mul_lsb_o       controller: current Q[0]
//   result_valid_o  product valid
//   result_ready_i  consumer accepts the product
//   product_o       registered product
module mul_datapath #(
  parameter int WIDTH = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [WIDTH-1:0]   multiplicand_i,
  input  logic [WIDTH-1:0]   multiplier_i,
  output logic               mul_enable_o,
  input  logic               load_reg_i,
  input  logic               add_i,
  input  logic               mux_ctrl_i,
  input  logic               shift_ena_i,
  output logic [1:0]         step_count_o,
  output logic               mul_lsb_o,
  output logic               result_valid_o,
  input  logic               result_ready_i,
  output logic [2*WIDTH-1:0] product_o
);

  // Accumulator carries one extra bit so the add never loses its carry.
  logic [WIDTH:0]       a_q,    a_d;
  logic [WIDTH-1:0]     q_q,    q_d;
  logic [WIDTH-1:0]     m_q,    m_d;
  logic [1:0]           cnt_q,  cnt_d;
  logic                 busy_q, busy_d;
  logic [2*WIDTH-1:0]   res_q,  res_d;
  logic                 rv_q,   rv_d;

  logic [WIDTH-1:0]     addend;

  // Next-state logic for the datapath registers and the result handshake.
  always_comb begin
    a_d    = a_q;
    q_d    = q_q;
    m_d    = m_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    res_d  = res_q;
    rv_d   = rv_q;
    addend = mux_ctrl_i ? m_q : {WIDTH{1'b0}};

    // Consumer handshake first so a completion in the same edge wins.
    if (rv_q && result_ready_i) begin
      rv_d = 1'b0;
    end else begin
      rv_d = rv_q;
    end

    // Load > add > shift if the controller ever asserts more than one.
    if (load_reg_i) begin
      a_d    = {(WIDTH+1){1'b0}};
      q_d    = multiplier_i;
      m_d    = multiplicand_i;
      cnt_d  = 2'd3;
      busy_d = 1'b1;
    end else if (add_i) begin
      // Carry from a previous add has already been shifted out of A[WIDTH].
      a_d = {1'b0, a_q[WIDTH-1:0]} + {1'b0, addend};
    end else if (shift_ena_i) begin
      a_d   = {1'b0, a_q[WIDTH:1]};
      q_d   = {a_q[0], q_q[WIDTH-1:1]};
      cnt_d = cnt_q - 2'd1;  // wraps to 3 on the final step; reloaded on load
      // Final step: capture the post-shift {A,Q}, taken here from pre-shift bits.
      // Gated by busy so stray shifts while idle never touch the result.
      if (busy_q && (cnt_q == 2'd0)) begin
        res_d  = {a_q[WIDTH:0], q_q[WIDTH-1:1]};
        rv_d   = 1'b1;
        busy_d = 1'b0;
      end else begin
        res_d  = res_q;
        busy_d = busy_q;
      end
    end else begin
      a_d = a_q;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      a_q    <= {(WIDTH+1){1'b0}};
      q_q    <= {WIDTH{1'b0}};
      m_q    <= {WIDTH{1'b0}};
      cnt_q  <= 2'd0;
      busy_q <= 1'b0;
      res_q  <= {(2*WIDTH){1'b0}};
      rv_q   <= 1'b0;
    end else begin
      a_q    <= a_d;
      q_q    <= q_d;
      m_q    <= m_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      res_q  <= res_d;
      rv_q   <= rv_d;
    end
  end

  // Ready depends only on state, so valid -> ready forms no loop.
  assign req_ready_o    = ~busy_q & ~rv_q;
  assign mul_enable_o   = req_valid_i & req_ready_o;
  assign step_count_o   = cnt_q;
  assign mul_lsb_o      = q_q[0];
  assign product_o      = res_q;
  assign result_valid_o = rv_q;

endmodule

// File: tb/tb_mul_datapath.sv
// Bench for mul_datapath. The bench plays the controller: on an accepted
// request it drives load, then four add/shift pairs. Expected products are
// pushed to a scoreboard queue at accept and popped by a monitor on every
// result handshake.
module tb_mul_datapath;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       req_valid_i = 1'b0;
  logic       req_ready_o;
  logic [3:0] multiplicand_i = 4'd0;
  logic [3:0] multiplier_i = 4'd0;
  logic       mul_enable_o;
  logic       load_reg_i = 1'b0;
  logic       add_i = 1'b0;
  logic       mux_ctrl_i = 1'b0;
  logic       shift_ena_i = 1'b0;
  logic [1:0] step_count_o;
  logic       mul_lsb_o;
  logic       result_valid_o;
  logic       result_ready_i = 1'b1;
  logic [7:0] product_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] sb[$];

  mul_datapath #(.WIDTH(4)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .multiplicand_i(multiplicand_i), .multiplier_i(multiplier_i),
    .mul_enable_o(mul_enable_o), .load_reg_i(load_reg_i), .add_i(add_i),
    .mux_ctrl_i(mux_ctrl_i), .shift_ena_i(shift_ena_i),
    .step_count_o(step_count_o), .mul_lsb_o(mul_lsb_o),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .product_o(product_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Inputs change right after the falling edge; the DUT samples at the rising edge.
  task automatic tick;
    @(negedge clk);
  endtask

  // Scoreboard monitor: pop and compare on every result handshake.
  always @(negedge clk) begin
    #2;
    if (!reset_i && result_valid_o === 1'b1 && result_ready_i === 1'b1) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        check("product", {24'd0, product_o}, {24'd0, sb.pop_front()});
      end
    end
  end

  task automatic do_reset;
    reset_i = 1'b1;
    req_valid_i = 1'b0; load_reg_i = 1'b0; add_i = 1'b0;
    shift_ena_i = 1'b0; mux_ctrl_i = 1'b0;
    sb.delete();
    tick;
    reset_i = 1'b0;
    #1;
    check("rst_req_ready", {31'd0, req_ready_o}, 32'd1);
    check("rst_result_valid", {31'd0, result_valid_o}, 32'd0);
    check("rst_product", {24'd0, product_o}, 32'd0);
    check("rst_step_count", {30'd0, step_count_o}, 32'd0);
    check("rst_mul_lsb", {31'd0, mul_lsb_o}, 32'd0);
  endtask

  // Accept one job and play the controller. abort_at = k resets at cycle T+k
  // (0 = run to completion). Returns the number of cycles spent waiting for ready.
  task automatic run_job(input logic [3:0] m, input logic [3:0] q,
                         input int abort_at, output int waited);
    int k;
    logic [7:0] exp_p;
    exp_p = 8'(m) * 8'(q);
    multiplicand_i = m;
    multiplier_i = q;
    req_valid_i = 1'b1;
    waited = 0;
    #1;
    while (req_ready_o !== 1'b1 && waited < 50) begin
      tick; #1; waited++;
    end
    if (req_ready_o !== 1'b1) begin
      check("accept_timeout", 32'd1, 32'd0);
      req_valid_i = 1'b0;
      return;
    end
    check("mul_enable", {31'd0, mul_enable_o}, 32'd1);
    load_reg_i = 1'b1;
    sb.push_back(exp_p);
    tick;                                   // now cycle T+1
    load_reg_i = 1'b0;
    req_valid_i = 1'b0;
    k = 1;
    for (int i = 0; i < 4; i++) begin
      // add cycle
      if (k == abort_at) begin do_reset; return; end
      #1;
      check("busy_not_ready", {31'd0, req_ready_o}, 32'd0);
      check("mul_lsb", {31'd0, mul_lsb_o}, {31'd0, q[i]});
      add_i = 1'b1;
      mux_ctrl_i = q[i];
      if (q == 4'd0) check("mux_low_q0", {31'd0, mux_ctrl_i}, 32'd0);
      tick; k++;
      add_i = 1'b0;
      mux_ctrl_i = 1'b0;
      // shift cycle
      if (k == abort_at) begin do_reset; return; end
      #1;
      check("step_count", {30'd0, step_count_o}, 32'(3 - i));
      shift_ena_i = 1'b1;
      tick; k++;
      shift_ena_i = 1'b0;
    end
    #1;                                     // cycle T+9
    check("result_valid_t9", {31'd0, result_valid_o}, 32'd1);
  endtask

  initial begin
    int w;
    do_reset;

    // Basic job with consumer always ready; valid for exactly one cycle.
    result_ready_i = 1'b1;
    run_job(4'd5, 4'd3, 0, w);
    tick; #1;
    check("rv_one_cycle", {31'd0, result_valid_o}, 32'd0);
    check("product_hold", {24'd0, product_o}, 32'h0F);

    // Stray shifts while idle must not complete a phantom job.
    for (int i = 0; i < 5; i++) begin
      shift_ena_i = 1'b1; tick;
    end
    shift_ena_i = 1'b0; #1;
    check("idle_rv", {31'd0, result_valid_o}, 32'd0);
    check("idle_product", {24'd0, product_o}, 32'h0F);
    check("idle_ready", {31'd0, req_ready_o}, 32'd1);
    tick;

    // Carry path and zero operands.
    run_job(4'd15, 4'd15, 0, w); tick;
    run_job(4'd13, 4'd11, 0, w); tick;
    run_job(4'd0,  4'd9,  0, w); tick;
    run_job(4'd9,  4'd0,  0, w); tick;

    // Backpressure: result held, next request stalled.
    result_ready_i = 1'b0;
    run_job(4'd11, 4'd12, 0, w);
    multiplicand_i = 4'd2; multiplier_i = 4'd3; req_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick; #1;
      check("bp_ready", {31'd0, req_ready_o}, 32'd0);
      check("bp_enable", {31'd0, mul_enable_o}, 32'd0);
      check("bp_valid", {31'd0, result_valid_o}, 32'd1);
      check("bp_product", {24'd0, product_o}, 32'h84);
    end
    tick;
    result_ready_i = 1'b1;
    #1;
    check("bp_release_ready", {31'd0, req_ready_o}, 32'd0);
    tick;
    run_job(4'd2, 4'd3, 0, w);
    check("bp_accept_next", 32'(w), 32'd0);
    tick;

    // Reset mid-job at T+4, then a clean job.
    run_job(4'd10, 4'd10, 4, w);
    run_job(4'd7, 4'd6, 0, w);
    tick; tick; #1;
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
